// File: rtl/avalon_mon_pkg.sv
// Shared types, error indices and small helpers for the passive Avalon bus monitor.
package avalon_mon_pkg;

  typedef enum logic [2:0] {
    MODE_WAITREQ    = 3'd0,
    MODE_FIXED_WAIT = 3'd1,
    MODE_PIPE_VAR   = 3'd2,
    MODE_PIPE_FIXED = 3'd3,
    MODE_BURST      = 3'd4
  } avalon_mode_e;

  localparam int E0 = 0;
  localparam int E1 = 1;
  localparam int E2 = 2;
  localparam int E3 = 3;
  localparam int E4 = 4;
  localparam int NUM_ERR = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WBURST = 1'b1
  } burst_state_e;

  function automatic bit mode_is(input int mode, input avalon_mode_e m);
    return mode == int'(m);
  endfunction

  function automatic bit mode_tracks_pending(input int mode);
    return (mode >= int'(MODE_PIPE_VAR)) && (mode <= int'(MODE_BURST));
  endfunction

  // Returns {violation, next hold count}; a count of zero means no request in flight.
  function automatic logic [8:0] hold_step(input logic req, input logic addr_chg,
                                           input logic [7:0] cnt, input logic [7:0] hold_len);
    logic       viol;
    logic [7:0] nxt;
    viol = (cnt != 8'd0) && (!req || addr_chg);
    nxt  = (viol ? 8'd0 : cnt) + 8'd1;
    if (!req || (nxt >= hold_len)) begin
      return {viol, 8'd0};
    end else begin
      return {viol, nxt};
    end
  endfunction

endpackage

// File: rtl/avalon_pending_tracker.sv
// Outstanding read-beat accounting: pending count, underflow, overflow and
// fixed-latency strobe checking.
module avalon_pending_tracker
  import avalon_mon_pkg::*;
#(
  parameter int AVALONMODE = 2,
  parameter int FIXEDDELAY = 2,
  parameter int MAXPENDING = 8,
  parameter int PW         = $clog2(MAXPENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_acc_i,
  input  logic [7:0]    add_i,
  input  logic          rdv_i,
  output logic [PW-1:0] pending_o,
  output logic          e2_o,
  output logic          e3_o,
  output logic          e4_o
);

  localparam bit ENABLE = mode_tracks_pending(AVALONMODE);
  localparam bit FIXED  = mode_is(AVALONMODE, MODE_PIPE_FIXED);
  localparam int SW     = PW + 9;

  logic [PW-1:0]         pending_q, pending_d;
  logic [FIXEDDELAY-1:0] shift_q, shift_d;
  logic [SW-1:0]         net_s;

  // Net pending change, saturation, and the per-read expected-strobe history.
  always_comb begin
    net_s = SW'(pending_q) + (rd_acc_i ? SW'(add_i) : '0);
    if (rdv_i && (pending_q != '0)) begin
      net_s = net_s - SW'(1'b1);
    end else begin
      net_s = net_s;
    end
    e2_o = ENABLE && rdv_i && (pending_q == '0);
    e4_o = ENABLE && (net_s > SW'(MAXPENDING));
    if (!ENABLE) begin
      pending_d = '0;
    end else if (e4_o) begin
      pending_d = PW'(MAXPENDING);
    end else begin
      pending_d = PW'(net_s);
    end
    if (FIXED) begin
      shift_d = (shift_q << 1) | FIXEDDELAY'(rd_acc_i);
    end else begin
      shift_d = '0;
    end
    e3_o = FIXED && (rdv_i != shift_q[FIXEDDELAY-1]);
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      shift_q   <= '0;
    end else begin
      pending_q <= pending_d;
      shift_q   <= shift_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/avalon_monitor.sv
// Passive Avalon-MM protocol monitor: sticky error flags E0..E4, a saturating
// violation-cycle counter, read-beat accounting and write-burst tracking.
module avalon_monitor
  import avalon_mon_pkg::*;
#(
  parameter int AVALONMODE  = 0,
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WRITEDELAY  = 2,
  parameter int READDELAY   = 1,
  parameter int FIXEDDELAY  = 2,
  parameter int MAXPENDING  = 8,
  parameter int CNTWIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NBADDRBITS-1:0]              address,
  input  logic [NBDATABYTES-1:0]             byteenable,
  input  logic [8*NBDATABYTES-1:0]           readdata,
  input  logic [8*NBDATABYTES-1:0]           writedata,
  input  logic                               read,
  input  logic                               write,
  input  logic                               waitrequest,
  input  logic                               readdatavalid,
  input  logic [7:0]                         burstcount,
  input  logic                               beginbursttransfer,
  input  logic                               clear_i,
  output logic [4:0]                         err_o,
  output logic [CNTWIDTH-1:0]                err_count_o,
  output logic [$clog2(MAXPENDING+1)-1:0]    pending_o,
  output logic [7:0]                         burst_remaining_o
);

  localparam int         PW            = $clog2(MAXPENDING + 1);
  localparam int         DW            = 8 * NBDATABYTES;
  localparam bit         IS_FIXED_WAIT = mode_is(AVALONMODE, MODE_FIXED_WAIT);
  localparam bit         IS_BURST      = mode_is(AVALONMODE, MODE_BURST);
  localparam logic [7:0] RD_HOLD       = 8'(READDELAY + 1);
  localparam logic [7:0] WR_HOLD       = 8'(WRITEDELAY + 1);

  logic                   rd_acc_s, wr_acc_s, e1_stall_s;
  logic                   prev_stall_q, prev_stall_d;
  logic                   prev_read_q, prev_read_d;
  logic                   prev_write_q, prev_write_d;
  logic [NBADDRBITS-1:0]  prev_address_q, prev_address_d;
  logic [NBDATABYTES-1:0] prev_byteenable_q, prev_byteenable_d;
  logic [DW-1:0]          prev_writedata_q, prev_writedata_d;
  logic [7:0]             prev_burstcount_q, prev_burstcount_d;
  logic [7:0]             rd_hold_q, rd_hold_d, wr_hold_q, wr_hold_d;
  logic [NBADDRBITS-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [8:0]             rd_step_s, wr_step_s;
  burst_state_e           state_q, state_d;
  logic [7:0]             remaining_q, remaining_d;
  logic                   burst_err_s, e2_s, e3_s, e4_pend_s;
  logic [NUM_ERR-1:0]     err_now_s, err_q, err_d;
  logic [CNTWIDTH-1:0]    count_q, count_d;
  logic                   unused_readdata;

  assign unused_readdata = ^readdata;

  // Handshake decode and the previous-cycle snapshot used by the stall-stability check.
  always_comb begin
    rd_acc_s          = read & ~waitrequest;
    wr_acc_s          = write & ~waitrequest;
    prev_stall_d      = (read | write) & waitrequest;
    prev_read_d       = read;
    prev_write_d      = write;
    prev_address_d    = address;
    prev_byteenable_d = byteenable;
    prev_writedata_d  = writedata;
    prev_burstcount_d = burstcount;
    e1_stall_s = prev_stall_q &&
                 ((read != prev_read_q) || (write != prev_write_q) ||
                  (address != prev_address_q) || (byteenable != prev_byteenable_q) ||
                  (writedata != prev_writedata_q) || (burstcount != prev_burstcount_q));
  end

  // Fixed-wait mode: a request must hold its address for the whole wait window.
  always_comb begin
    rd_step_s = hold_step(read, address != rd_addr_q, rd_hold_q, RD_HOLD);
    wr_step_s = hold_step(write, address != wr_addr_q, wr_hold_q, WR_HOLD);
    if (IS_FIXED_WAIT) begin
      rd_hold_d = rd_step_s[7:0];
      wr_hold_d = wr_step_s[7:0];
      rd_addr_d = read ? address : rd_addr_q;
      wr_addr_d = write ? address : wr_addr_q;
    end else begin
      rd_hold_d = 8'd0;
      wr_hold_d = 8'd0;
      rd_addr_d = '0;
      wr_addr_d = '0;
    end
  end

  // Write-burst tracking: beat countdown and reads that intrude on a burst.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    burst_err_s = 1'b0;
    if (IS_BURST) begin
      case (state_q)
        ST_IDLE: begin
          if (wr_acc_s && beginbursttransfer) begin
            if (burstcount == 8'd0) begin
              burst_err_s = 1'b1;
            end else if (burstcount == 8'd1) begin
              remaining_d = 8'd0;
            end else begin
              state_d     = ST_WBURST;
              remaining_d = burstcount - 8'd1;
            end
          end else begin
            remaining_d = 8'd0;
          end
        end
        ST_WBURST: begin
          burst_err_s = rd_acc_s;
          if (wr_acc_s) begin
            remaining_d = remaining_q - 8'd1;
            state_d     = (remaining_q == 8'd1) ? ST_IDLE : ST_WBURST;
          end else begin
            remaining_d = remaining_q;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          remaining_d = 8'd0;
        end
      endcase
    end else begin
      state_d     = ST_IDLE;
      remaining_d = 8'd0;
    end
  end

  avalon_pending_tracker #(
    .AVALONMODE (AVALONMODE),
    .FIXEDDELAY (FIXEDDELAY),
    .MAXPENDING (MAXPENDING),
    .PW         (PW)
  ) u_pending (
    .clk       (clk),
    .rst       (rst),
    .rd_acc_i  (rd_acc_s),
    .add_i     (IS_BURST ? burstcount : 8'd1),
    .rdv_i     (readdatavalid),
    .pending_o (pending_o),
    .e2_o      (e2_s),
    .e3_o      (e3_s),
    .e4_o      (e4_pend_s)
  );

  // Collect this cycle's violations; a same-cycle violation outranks clear_i.
  always_comb begin
    err_now_s     = '0;
    err_now_s[E0] = read & write;
    if (IS_FIXED_WAIT) begin
      err_now_s[E1] = rd_step_s[8] | wr_step_s[8];
    end else begin
      err_now_s[E1] = e1_stall_s;
    end
    err_now_s[E2] = e2_s;
    err_now_s[E3] = e3_s;
    err_now_s[E4] = e4_pend_s | burst_err_s;
    if (clear_i) begin
      err_d   = err_now_s;
      count_d = (err_now_s != '0) ? CNTWIDTH'(1'b1) : '0;
    end else if ((err_now_s != '0) && (count_q != {CNTWIDTH{1'b1}})) begin
      err_d   = err_q | err_now_s;
      count_d = count_q + CNTWIDTH'(1'b1);
    end else begin
      err_d   = err_q | err_now_s;
      count_d = count_q;
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_stall_q      <= 1'b0;
      prev_read_q       <= 1'b0;
      prev_write_q      <= 1'b0;
      prev_address_q    <= '0;
      prev_byteenable_q <= '0;
      prev_writedata_q  <= '0;
      prev_burstcount_q <= 8'd0;
      rd_hold_q         <= 8'd0;
      wr_hold_q         <= 8'd0;
      rd_addr_q         <= '0;
      wr_addr_q         <= '0;
      state_q           <= ST_IDLE;
      remaining_q       <= 8'd0;
      err_q             <= '0;
      count_q           <= '0;
    end else begin
      prev_stall_q      <= prev_stall_d;
      prev_read_q       <= prev_read_d;
      prev_write_q      <= prev_write_d;
      prev_address_q    <= prev_address_d;
      prev_byteenable_q <= prev_byteenable_d;
      prev_writedata_q  <= prev_writedata_d;
      prev_burstcount_q <= prev_burstcount_d;
      rd_hold_q         <= rd_hold_d;
      wr_hold_q         <= wr_hold_d;
      rd_addr_q         <= rd_addr_d;
      wr_addr_q         <= wr_addr_d;
      state_q           <= state_d;
      remaining_q       <= remaining_d;
      err_q             <= err_d;
      count_q           <= count_d;
    end
  end

  assign err_o             = err_q;
  assign err_count_o       = count_q;
  assign burst_remaining_o = remaining_q;

endmodule

// File: tb/tb_avalon_monitor.sv
// One monitor per AVALONMODE on shared bus stimulus, each checked every cycle
// against a cycle-level reference model of the protocol rules.
module tb_avalon_monitor;

  localparam int NM   = 5;
  localparam int RDL  = 1;
  localparam int WRL  = 2;
  localparam int FD   = 2;
  localparam int MAXP = 8;
  localparam int CW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, read, write, waitrequest, readdatavalid, beginbursttransfer, clear_i;
  logic [7:0]  address, burstcount;
  logic [1:0]  byteenable;
  logic [15:0] readdata, writedata;

  logic [4:0]  err_w  [NM];
  logic [3:0]  cnt_w  [NM];
  logic [3:0]  pend_w [NM];
  logic [7:0]  rem_w  [NM];

  for (genvar m = 0; m < NM; m++) begin : g_dut
    avalon_monitor #(
      .AVALONMODE(m), .NBDATABYTES(2), .NBADDRBITS(8), .WRITEDELAY(WRL),
      .READDELAY(RDL), .FIXEDDELAY(FD), .MAXPENDING(MAXP), .CNTWIDTH(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .address(address), .byteenable(byteenable),
      .readdata(readdata), .writedata(writedata), .read(read), .write(write),
      .waitrequest(waitrequest), .readdatavalid(readdatavalid),
      .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
      .clear_i(clear_i), .err_o(err_w[m]), .err_count_o(cnt_w[m]),
      .pending_o(pend_w[m]), .burst_remaining_o(rem_w[m])
    );
  end

  int          n_checks, n_errors, cyc;
  logic [4:0]  m_err  [NM];
  int          m_cnt  [NM];
  int          m_pend [NM];
  int          m_rem  [NM];
  int          rd_start, wr_start;
  logic [7:0]  rd_addr, wr_addr;
  bit          acc_hist [int];
  logic        p_stall, p_read, p_write;
  logic [7:0]  p_addr, p_bc;
  logic [1:0]  p_be;
  logic [15:0] p_wd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fixed-wait rule: a request started at cycle 'start' must stay up on the same address for len cycles.
  task automatic hold_track(input logic req, input logic [7:0] addr, input int len,
                            inout int start, inout logic [7:0] saddr, output bit viol);
    bit fresh;
    viol  = 1'b0;
    fresh = (start < 0);
    if (!fresh) begin
      if (!req || addr != saddr) begin
        viol  = 1'b1;
        fresh = 1'b1;
        start = -1;
      end else if (cyc - start + 1 >= len) begin
        start = -1;
      end
    end
    if (fresh && req) begin
      start = cyc;
      saddr = addr;
      if (len <= 1) start = -1;
    end
  endtask

  task automatic model_step();
    bit         racc, wacc, e1s, rv, wv, exp_rdv;
    logic [4:0] e;
    int         np, add;
    if (rst) begin
      for (int m = 0; m < NM; m++) begin
        m_err[m] = '0; m_cnt[m] = 0; m_pend[m] = 0; m_rem[m] = 0;
      end
      rd_start = -1; wr_start = -1;
      acc_hist.delete();
      p_stall = 1'b0;
      cyc++;
      return;
    end
    racc = read && !waitrequest;
    wacc = write && !waitrequest;
    e1s  = p_stall && (read != p_read || write != p_write || address != p_addr ||
                       byteenable != p_be || writedata != p_wd || burstcount != p_bc);
    hold_track(read, address, RDL + 1, rd_start, rd_addr, rv);
    hold_track(write, address, WRL + 1, wr_start, wr_addr, wv);
    exp_rdv = acc_hist.exists(cyc - FD) != 0;
    for (int m = 0; m < NM; m++) begin
      e    = '0;
      e[0] = read && write;
      e[1] = (m == 1) ? (rv || wv) : e1s;
      if (m >= 2) begin
        add = !racc ? 0 : ((m == 4) ? int'(burstcount) : 1);
        if (readdatavalid && m_pend[m] == 0) e[2] = 1'b1;
        np = m_pend[m] + add - ((readdatavalid && m_pend[m] > 0) ? 1 : 0);
        if (np > MAXP) begin
          e[4] = 1'b1;
          np   = MAXP;
        end
        m_pend[m] = np;
      end
      if (m == 3 && readdatavalid != exp_rdv) e[3] = 1'b1;
      if (m == 4) begin
        if (m_rem[m] > 0) begin
          if (racc) e[4] = 1'b1;
          if (wacc) m_rem[m]--;
        end else if (wacc && beginbursttransfer) begin
          if (burstcount == 0) e[4] = 1'b1;
          else m_rem[m] = int'(burstcount) - 1;
        end
      end
      if (clear_i) begin
        m_err[m] = e;
        m_cnt[m] = (e != 0) ? 1 : 0;
      end else begin
        m_err[m] = m_err[m] | e;
        if (e != 0 && m_cnt[m] < (1 << CW) - 1) m_cnt[m]++;
      end
    end
    if (racc) acc_hist[cyc] = 1'b1;
    p_stall = (read || write) && waitrequest;
    p_read = read; p_write = write; p_addr = address;
    p_be = byteenable; p_wd = writedata; p_bc = burstcount;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int m = 0; m < NM; m++) begin
      check_eq($sformatf("m%0d_err", m),  32'(err_w[m]),  32'(m_err[m]));
      check_eq($sformatf("m%0d_cnt", m),  32'(cnt_w[m]),  m_cnt[m]);
      check_eq($sformatf("m%0d_pend", m), 32'(pend_w[m]), m_pend[m]);
      check_eq($sformatf("m%0d_rem", m),  32'(rem_w[m]),  m_rem[m]);
    end
  endtask

  task automatic idle();
    rst = 1'b0; read = 1'b0; write = 1'b0; waitrequest = 1'b0; readdatavalid = 1'b0;
    beginbursttransfer = 1'b0; clear_i = 1'b0; address = 8'h00; burstcount = 8'd0;
    byteenable = 2'b00; readdata = 16'h0000; writedata = 16'h0000;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rd_start = -1; wr_start = -1; rd_addr = 8'h00; wr_addr = 8'h00;
    do_reset();
    tick();

    // Mode 0: address changes while stalled
    read = 1'b1; waitrequest = 1'b1; address = 8'h10; tick();
    address = 8'h11; tick();
    tick();
    waitrequest = 1'b0; tick();
    idle(); tick();
    check_eq("m0_stall_err", 32'(err_w[0]), 32'h02);
    check_eq("m0_stall_cnt", 32'(cnt_w[0]), 32'd1);

    // Mode 2: pending up/down, then underflow
    do_reset();
    read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("m2_pend_up", 32'(pend_w[2]), i + 1);
    end
    read = 1'b0; readdatavalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("m2_pend_down", 32'(pend_w[2]), 2 - i);
    end
    tick();
    check_eq("m2_underflow_e2", 32'(err_w[2][2]), 32'd1);
    check_eq("m2_underflow_pend", 32'(pend_w[2]), 32'd0);

    // Mode 3: late strobe flags, on-time strobe does not
    do_reset();
    read = 1'b1; tick(); idle(); tick(); tick();
    readdatavalid = 1'b1; tick(); idle(); tick();
    check_eq("m3_late_e3", 32'(err_w[3][3]), 32'd1);
    do_reset();
    read = 1'b1; tick(); idle(); tick();
    readdatavalid = 1'b1; tick(); idle(); tick(); tick();
    check_eq("m3_ontime_err", 32'(err_w[3]), 32'd0);
    check_eq("m3_ontime_cnt", 32'(cnt_w[3]), 32'd0);

    // Mode 4: clean burst of 4, then a read inside a burst
    do_reset();
    write = 1'b1; beginbursttransfer = 1'b1; burstcount = 8'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("m4_burst_rem", 32'(rem_w[4]), 3 - i);
      beginbursttransfer = 1'b0;
    end
    idle(); tick();
    check_eq("m4_burst_err", 32'(err_w[4]), 32'd0);
    write = 1'b1; beginbursttransfer = 1'b1; burstcount = 8'd4; tick();
    write = 1'b0; beginbursttransfer = 1'b0; read = 1'b1; tick();
    check_eq("m4_read_in_burst", 32'(err_w[4][4]), 32'd1);
    idle(); tick();

    // All modes: read&write twice, clear, clear against a new violation
    do_reset();
    read = 1'b1; write = 1'b1; burstcount = 8'd1; tick(); tick();
    for (int m = 0; m < NM; m++) check_eq($sformatf("m%0d_rw_cnt2", m), 32'(cnt_w[m]), 32'd2);
    idle(); clear_i = 1'b1; tick();
    check_eq("m0_cleared", 32'(cnt_w[0]), 32'd0);
    check_eq("m2_cleared", 32'(cnt_w[2]), 32'd0);
    check_eq("m4_cleared", 32'(err_w[4]), 32'd0);
    read = 1'b1; write = 1'b1; burstcount = 8'd1; tick();
    for (int m = 0; m < NM; m++) begin
      check_eq($sformatf("m%0d_clr_viol_cnt", m), 32'(cnt_w[m]), 32'd1);
      check_eq($sformatf("m%0d_clr_viol_e0", m), 32'(err_w[m][0]), 32'd1);
    end
    idle(); tick();

    // Counter and pending saturation
    do_reset();
    read = 1'b1; write = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("m0_cnt_sat", 32'(cnt_w[0]), 32'd15);
    check_eq("m2_pend_sat", 32'(pend_w[2]), 32'd8);
    check_eq("m2_overflow_e4", 32'(err_w[2][4]), 32'd1);

    // Reset with reads outstanding and mid-burst
    do_reset();
    read = 1'b1; burstcount = 8'd1;
    for (int i = 0; i < 5; i++) tick();
    idle(); tick();
    check_eq("m2_pend5", 32'(pend_w[2]), 32'd5);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("m2_rst_pend", 32'(pend_w[2]), 32'd0);
    check_eq("m2_rst_err", 32'(err_w[2]), 32'd0);
    write = 1'b1; beginbursttransfer = 1'b1; burstcount = 8'd4; tick();
    beginbursttransfer = 1'b0; tick();
    idle(); rst = 1'b1; tick(); rst = 1'b0; tick();
    check_eq("m4_rst_rem", 32'(rem_w[4]), 32'd0);
    check_eq("m4_rst_err", 32'(err_w[4]), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      clear_i = ($urandom_range(0, 7) == 0);
      if (waitrequest && (read || write) && $urandom_range(0, 3) != 0) begin
        waitrequest = ($urandom_range(0, 1) == 0);
      end else begin
        read               = ($urandom_range(0, 2) == 0);
        write              = ($urandom_range(0, 3) == 0);
        address            = 8'($urandom_range(0, 3));
        byteenable         = 2'($urandom);
        writedata          = 16'($urandom_range(0, 3));
        burstcount         = 8'($urandom_range(0, 4));
        beginbursttransfer = ($urandom_range(0, 2) == 0);
        waitrequest        = ($urandom_range(0, 2) == 0);
      end
      readdatavalid = ($urandom_range(0, 3) == 0);
      readdata      = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avalon_monitor.md
AVALON_MONITOR -- requirements
Module: avalon_monitor

Interface
REQ-001 Parameters SHALL be:
- AVALONMODE, default 0: 0 wait-request, 1 fixed wait, 2 pipeline variable, 3 pipeline fixed, 4 burst.
- NBDATABYTES, default 2: bytes per data word.
- NBADDRBITS, default 8: address width.
- WRITEDELAY, default 2: mode 1 write wait cycles.
- READDELAY, default 1: mode 1 read wait cycles.
- FIXEDDELAY, default 2: mode 3 read latency.
- MAXPENDING, default 8: maximum outstanding read beats.
- CNTWIDTH, default 16: error counter width.

REQ-002 Ports SHALL be:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- address, input, NBADDRBITS: observed address.
- byteenable, input, NBDATABYTES: observed byte enables.
- readdata, input, 8*NBDATABYTES: observed read data.
- writedata, input, 8*NBDATABYTES: observed write data.
- read, input, 1: observed read request.
- write, input, 1: observed write request.
- waitrequest, input, 1: observed slave stall.
- readdatavalid, input, 1: observed read data strobe.
- burstcount, input, 8: observed burst length.
- beginbursttransfer, input, 1: observed burst start.
- clear_i, input, 1: clears err_o and err_count_o.
- err_o, output, 5: sticky error flags E0..E4.
- err_count_o, output, CNTWIDTH: count of cycles with at least one error.
- pending_o, output, $clog2(MAXPENDING+1): outstanding read beats.
- burst_remaining_o, output, 8: write-burst beats left.

Function
REQ-003 The block SHALL be passive: no input is driven, and a read or write is accepted on a cycle where it is high and waitrequest is low.
REQ-004 E0 SHALL set when read and write are both high in the same cycle (all modes).
REQ-005 E1 (modes 0, 2, 3, 4) SHALL set when the previous cycle had (read|write)&waitrequest and, in the current cycle, read, write, address, byteenable, writedata or burstcount differ from the previous cycle.
REQ-006 E1 (mode 1) SHALL set when a read (write) deasserts or changes address before READDELAY+1 (WRITEDELAY+1) consecutive cycles; the hold counter SHALL restart on the cycle after completion.
REQ-007 pending_o (modes 2-4) SHALL change as follows:
- +1 per accepted read, or +burstcount in mode 4.
- -1 per readdatavalid.
- Simultaneous add and subtract SHALL apply the net change in the same cycle.
REQ-008 E2 SHALL set on readdatavalid while pending_o==0; pending_o SHALL then remain 0.
REQ-009 E3 (mode 3 only) SHALL set when readdatavalid is not asserted exactly FIXEDDELAY cycles after each accepted read, tracked by a FIXEDDELAY-deep shift register; both a missing and an early strobe SHALL flag.
REQ-010 E4 SHALL set when an increment would exceed MAXPENDING; pending_o SHALL saturate at MAXPENDING.
REQ-011 Burst writes (mode 4) SHALL be tracked with states IDLE and WBURST:
- IDLE->WBURST on accepted write with beginbursttransfer, loading burst_remaining_o=burstcount-1; burstcount=1 SHALL stay in IDLE.
- Each accepted write in WBURST SHALL decrement burst_remaining_o; reaching 0 returns to IDLE.
- An accepted read in WBURST, or burstcount==0 at burst start, SHALL set E4.
REQ-012 err_o bits SHALL be sticky, set one cycle after the violating cycle.
REQ-013 err_count_o SHALL increment by exactly 1 per violating cycle regardless of how many bits fire, and SHALL saturate at all-ones.
REQ-014 clear_i SHALL zero err_o and err_count_o on the next edge; a violation in the same cycle SHALL take priority (flag set, count=1).
REQ-015 Checks disabled by AVALONMODE SHALL never set their flags.

Reset
REQ-016 When rst is high at a clock edge, err_o, err_count_o, pending_o and burst_remaining_o SHALL be 0, the FSM SHALL be IDLE, and the shift and hold counters SHALL be cleared.
REQ-017 Reset mid-burst or mid-read SHALL discard all tracking, and no error SHALL be raised for the abandoned transfer.

Structure
REQ-018 Package avalon_mon_pkg SHALL hold the mode enum, the error-index constants E0..E4 and the burst FSM state enum.
REQ-019 Outstanding-read accounting (REQ-007..REQ-010) SHALL live in sub-module avalon_pending_tracker.

Verification
REQ-020 Benches SHALL cover the following directed scenarios:
- Mode 0: read+waitrequest for 3 cycles with address changing 0x10->0x11 on cycle 2 -> err_o[1]=1, err_count_o=1.
- Mode 2: 3 accepted reads then 3 readdatavalid -> pending_o 1,2,3,2,1,0; a 4th readdatavalid -> err_o[2]=1.
- Mode 3, FIXEDDELAY=2: read accepted at cycle 10, readdatavalid at 13 -> err_o[3]=1; readdatavalid at 12 -> no error.
- Mode 4: write burst with burstcount=4 and 4 accepted beats -> burst_remaining_o 3,2,1,0, FSM IDLE, no error; a read at beat 2 -> err_o[4]=1.
- All modes: read&write together for 2 cycles, then clear_i -> err_count_o=2, then 0 after clear; clear_i concurrent with a new violation -> err_count_o=1.
- Mode 2: rst asserted with pending_o=5 -> pending_o=0 next cycle, err_o=0.
